puf_soc_batch_cntrlr: RTL and testbench

Parametrised, multi-challenge successor to the PUF SoC controller FSM. It buffers a batch of `NUM_CHAL` challenge words, each carrying a pair of ring-oscillator mux selects. It then sequences decode, execute and transmit/dump for each buffered challenge in turn. Over the single-shot controller it adds an execute timeout, a per-batch latched operating mode, abort, and a batch-done pulse. It sits between the UART receive/transmit datapath and the RO-PUF mux/counter execution core.

---
 rtl/puf_soc_batch_cntrlr_if.sv | 68 ++++++
 rtl/puf_soc_batch_cntrlr.sv | 249 ++++++++++++++++++++++++
 tb/tb_puf_soc_batch_cntrlr.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_soc_batch_cntrlr_if.sv
// -----------------------------------------------------------------------------
// puf_soc_batch_cntrlr_if
// Handshake and status bundle between the batch controller and its
// surroundings: UART receive/transmit datapath, RO-PUF execution core and the
// host start/abort controls.
//
// Parameters
//   MUX_LENGTH : RO mux inputs per mux (select width SW = clog2(MUX_LENGTH))
//   NUM_CHAL   : challenges per batch (index width IW = max(1, clog2(NUM_CHAL)))
//
// Modports
//   master : host/datapath side, drives the i_* signals, observes the o_* ones
//   slave  : controller side, consumes the i_* signals, drives the o_* ones
// -----------------------------------------------------------------------------
interface puf_soc_batch_cntrlr_if #(
    parameter int unsigned MUX_LENGTH = 16,
    parameter int unsigned NUM_CHAL   = 4
);
    localparam int unsigned SW = $clog2(MUX_LENGTH);
    localparam int unsigned IW = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;

    // host controls
    logic            i_start;
    logic            i_op_mode;
    logic            i_abort;

    // challenge receive
    logic            i_rx_valid;
    logic [2*SW-1:0] i_rx_data;
    logic            o_rx_ready;

    // execution / transmit / dump completion
    logic            i_exec_done;
    logic            i_tx_done;
    logic            i_dump_done;

    // status and stage enables
    logic [2:0]      o_fsm_state;
    logic            o_dcod_enable;
    logic            o_exec_enable;
    logic            o_tx_enable;
    logic            o_dump_enable;
    logic [SW-1:0]   o_sel_mux_0;
    logic [SW-1:0]   o_sel_mux_1;
    logic [IW-1:0]   o_chal_idx;
    logic            o_batch_done;
    logic            o_timeout;

    modport master (
        output i_start, i_op_mode, i_abort,
        output i_rx_valid, i_rx_data,
        output i_exec_done, i_tx_done, i_dump_done,
        input  o_rx_ready, o_fsm_state,
        input  o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable,
        input  o_sel_mux_0, o_sel_mux_1, o_chal_idx,
        input  o_batch_done, o_timeout
    );

    modport slave (
        input  i_start, i_op_mode, i_abort,
        input  i_rx_valid, i_rx_data,
        input  i_exec_done, i_tx_done, i_dump_done,
        output o_rx_ready, o_fsm_state,
        output o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable,
        output o_sel_mux_0, o_sel_mux_1, o_chal_idx,
        output o_batch_done, o_timeout
    );
endinterface

// File: rtl/puf_soc_batch_cntrlr.sv
// -----------------------------------------------------------------------------
// puf_soc_batch_cntrlr
// Batch controller for the RO-PUF SoC. Buffers NUM_CHAL challenge words, then
// runs decode -> execute -> transmit (normal mode) or dump (debug mode) for
// each buffered challenge in order. Adds an execute timeout, a per-batch
// latched mode, a synchronous abort and a one-cycle batch-done pulse.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : puf_soc_batch_cntrlr_if.slave
//          in : i_start, i_op_mode, i_abort, i_rx_valid, i_rx_data,
//               i_exec_done, i_tx_done, i_dump_done
//          out: o_rx_ready, o_fsm_state, o_dcod/exec/tx/dump_enable,
//               o_sel_mux_0/1, o_chal_idx, o_batch_done, o_timeout
// -----------------------------------------------------------------------------
module puf_soc_batch_cntrlr #(
    parameter int unsigned MUX_LENGTH  = 16,
    parameter int unsigned NUM_CHAL    = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    puf_soc_batch_cntrlr_if.slave bus
);

    localparam int unsigned SW = $clog2(MUX_LENGTH);
    localparam int unsigned IW = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned DW = 2 * SW;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHAL - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECEIVE  = 3'd1,
        S_DECODE   = 3'd2,
        S_EXECUTE  = 3'd3,
        S_TRANSMIT = 3'd4,
        S_DUMP     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // datapath registers
    logic [DW-1:0]  chal_buf [NUM_CHAL];
    logic [IW-1:0]  wr_cnt;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  timer;
    logic           mode;
    logic           timeout;
    logic [SW-1:0]  sel_mux_0;
    logic [SW-1:0]  sel_mux_1;

    // registered stage decodes
    logic           rx_ready;
    logic           dcod_enable;
    logic           exec_enable;
    logic           tx_enable;
    logic           dump_enable;
    logic           batch_done;

    // strobes from the next-state logic
    logic           start_acc;
    logic           buf_wr;
    logic           idx_clr;
    logic           idx_inc;
    logic           tmo_set;
    logic           abort_clr;
    logic           advance;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; abort overrides everything but reset
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        buf_wr    = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        tmo_set   = 1'b0;
        abort_clr = 1'b0;
        advance   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = S_RECEIVE;
                    start_acc = 1'b1;
                end
            end
            S_RECEIVE: begin
                if (bus.i_rx_valid && rx_ready) begin
                    buf_wr = 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        state_nxt = S_DECODE;
                        idx_clr   = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                // done beats a timeout landing in the same cycle
                if (bus.i_exec_done) begin
                    state_nxt = mode ? S_DUMP : S_TRANSMIT;
                end else if (timer == TMO_MAX) begin
                    tmo_set = 1'b1;
                    advance = 1'b1;
                end
            end
            S_TRANSMIT: begin
                if (bus.i_tx_done) begin
                    advance = 1'b1;
                end
            end
            S_DUMP: begin
                if (bus.i_dump_done) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // move to the next challenge, or finish the batch
        if (advance) begin
            if (idx == LAST_IDX) begin
                state_nxt = S_DONE;
            end else begin
                state_nxt = S_DECODE;
                idx_inc   = 1'b1;
            end
        end

        if (bus.i_abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            start_acc = 1'b0;
            buf_wr    = 1'b0;
            idx_clr   = 1'b0;
            idx_inc   = 1'b0;
            tmo_set   = 1'b0;
            abort_clr = 1'b1;
        end
    end

    // Stage enables registered from the next state so they track the state
    // register cycle for cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready    <= 1'b0;
            dcod_enable <= 1'b0;
            exec_enable <= 1'b0;
            tx_enable   <= 1'b0;
            dump_enable <= 1'b0;
            batch_done  <= 1'b0;
        end else begin
            rx_ready    <= (state_nxt == S_RECEIVE);
            dcod_enable <= (state_nxt == S_DECODE);
            exec_enable <= (state_nxt == S_EXECUTE);
            tx_enable   <= (state_nxt == S_TRANSMIT);
            dump_enable <= (state_nxt == S_DUMP);
            batch_done  <= (state_nxt == S_DONE);
        end
    end

    // Challenge buffer; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            chal_buf[wr_cnt] <= bus.i_rx_data;
        end
    end

    // Counters, latched mode, sticky timeout and mux selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            idx       <= '0;
            timer     <= '0;
            mode      <= 1'b0;
            timeout   <= 1'b0;
            sel_mux_0 <= '0;
            sel_mux_1 <= '0;
        end else begin
            if (start_acc) begin
                mode    <= bus.i_op_mode;
                wr_cnt  <= '0;
                timeout <= 1'b0;
            end

            if (buf_wr) begin
                wr_cnt <= wr_cnt + IW'(1);
            end

            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + IW'(1);
            end

            // selects load at the closing edge of DECODE, timer restarts
            if ((state == S_DECODE) && !abort_clr) begin
                sel_mux_0 <= chal_buf[idx][SW-1:0];
                sel_mux_1 <= chal_buf[idx][DW-1:SW];
                timer     <= '0;
            end else if (state == S_EXECUTE) begin
                timer <= timer + TW'(1);
            end

            if (tmo_set) begin
                timeout <= 1'b1;
            end

            if (abort_clr) begin
                wr_cnt <= '0;
                idx    <= '0;
                timer  <= '0;
            end
        end
    end

    assign bus.o_fsm_state   = state;
    assign bus.o_rx_ready    = rx_ready;
    assign bus.o_dcod_enable = dcod_enable;
    assign bus.o_exec_enable = exec_enable;
    assign bus.o_tx_enable   = tx_enable;
    assign bus.o_dump_enable = dump_enable;
    assign bus.o_batch_done  = batch_done;
    assign bus.o_sel_mux_0   = sel_mux_0;
    assign bus.o_sel_mux_1   = sel_mux_1;
    assign bus.o_chal_idx    = idx;
    assign bus.o_timeout     = timeout;

endmodule

// File: tb/tb_puf_soc_batch_cntrlr.sv
// -----------------------------------------------------------------------------
// tb_puf_soc_batch_cntrlr
// Directed bench for puf_soc_batch_cntrlr (MUX_LENGTH=16, NUM_CHAL=4,
// TIMEOUT_CYC=8). A responder answers the execute/transmit/dump handshakes
// with programmable latencies; a monitor logs bursts and selects.
// -----------------------------------------------------------------------------
module tb_puf_soc_batch_cntrlr;

    logic clk;
    logic rst;

    puf_soc_batch_cntrlr_if #(.MUX_LENGTH(16), .NUM_CHAL(4)) bus ();

    puf_soc_batch_cntrlr #(
        .MUX_LENGTH (16),
        .NUM_CHAL   (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {rx_ready, dcod, exec, tx, dump, batch_done, timeout}
    logic [6:0] outs;
    assign outs = {bus.o_rx_ready, bus.o_dcod_enable, bus.o_exec_enable,
                   bus.o_tx_enable, bus.o_dump_enable, bus.o_batch_done, bus.o_timeout};

    // ---------------- responder ----------------
    int exec_lat = 3;
    int tx_lat   = 2;
    int dump_lat = 2;
    int skip_idx = -1;
    bit tx_spam  = 1'b0;

    initial begin
        int ec;
        int tc;
        int dc;
        bit tog;
        ec  = 0;
        tc  = 0;
        dc  = 0;
        tog = 1'b0;
        bus.i_exec_done = 1'b0;
        bus.i_tx_done   = 1'b0;
        bus.i_dump_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ec  = bus.o_exec_enable ? ec + 1 : 0;
            tc  = bus.o_tx_enable   ? tc + 1 : 0;
            dc  = bus.o_dump_enable ? dc + 1 : 0;
            tog = ~tog;
            bus.i_exec_done = bus.o_exec_enable && (ec == exec_lat) &&
                              (int'(bus.o_chal_idx) != skip_idx);
            bus.i_tx_done   = (bus.o_tx_enable && (tc == tx_lat)) || (tx_spam && tog);
            bus.i_dump_done = bus.o_dump_enable && (dc == dump_lat);
        end
    end

    // ---------------- monitor ----------------
    int tx_rises   = 0;
    int dump_rises = 0;
    int done_cyc   = 0;
    int exec_rises = 0;
    int exec_falls = 0;
    int exec_run   = 0;
    logic [7:0] sel_log [64];
    int         len_log [64];
    logic tx_q   = 1'b0;
    logic dump_q = 1'b0;
    logic exec_q = 1'b0;

    always @(negedge clk) begin
        if (bus.o_tx_enable && !tx_q)     tx_rises++;
        if (bus.o_dump_enable && !dump_q) dump_rises++;
        if (bus.o_batch_done)             done_cyc++;
        if (bus.o_exec_enable) begin
            if (!exec_q) begin
                sel_log[exec_rises % 64] = {bus.o_sel_mux_1, bus.o_sel_mux_0};
                exec_rises++;
                exec_run = 0;
            end
            exec_run++;
        end else if (exec_q) begin
            len_log[exec_falls % 64] = exec_run;
            exec_falls++;
        end
        tx_q   = bus.o_tx_enable;
        dump_q = bus.o_dump_enable;
        exec_q = bus.o_exec_enable;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_batch(input logic m);
        bus.i_start   = 1'b1;
        bus.i_op_mode = m;
        cyc(1);
        bus.i_start   = 1'b0;
        bus.i_op_mode = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = w;
        cyc(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int b;
        b = budget;
        while ((bus.o_fsm_state != st) && (b > 0)) begin
            cyc(1);
            b--;
        end
        check(tag, 32'(bus.o_fsm_state), 32'(st));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int b_tx;
    int b_dump;
    int b_done;
    int b_exec;
    int b_fall;
    bit hit;

    initial begin
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_op_mode  = 1'b0;
        bus.i_abort    = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        cyc(3);

        // reset state
        check("rst_state", 32'(bus.o_fsm_state), 32'd0);
        check("rst_outs",  32'(outs), 32'd0);
        check("rst_sel",   32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'd0);
        check("rst_idx",   32'(bus.o_chal_idx), 32'd0);
        rst = 1'b0;
        cyc(2);

        // normal batch
        b_tx = tx_rises; b_dump = dump_rises; b_done = done_cyc;
        b_exec = exec_rises; b_fall = exec_falls;
        start_batch(1'b0);
        check("n_recv_state", 32'(bus.o_fsm_state), 32'd1);
        check("n_rx_ready",   32'(bus.o_rx_ready), 32'd1);
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'h56);
        send_word(8'h78);
        check("n_decode_state", 32'(bus.o_fsm_state), 32'd2);
        check("n_dcod_en",      32'(outs), 32'b0100000);
        cyc(1);
        check("n_first_exec",   32'(bus.o_fsm_state), 32'd3);
        wait_state(3'd0, 200, "n_end_idle");
        check("n_sel0", 32'(sel_log[b_exec % 64]),       32'h12);
        check("n_sel1", 32'(sel_log[(b_exec + 1) % 64]), 32'h34);
        check("n_sel2", 32'(sel_log[(b_exec + 2) % 64]), 32'h56);
        check("n_sel3", 32'(sel_log[(b_exec + 3) % 64]), 32'h78);
        check("n_exec_len", 32'(len_log[b_fall % 64]), 32'd3);
        check("n_tx_bursts",  32'(tx_rises - b_tx),     32'd4);
        check("n_dump_bursts",32'(dump_rises - b_dump), 32'd0);
        check("n_done_pulse", 32'(done_cyc - b_done),   32'd1);
        check("n_hold_m0",    32'(bus.o_sel_mux_0), 32'd8);
        check("n_hold_m1",    32'(bus.o_sel_mux_1), 32'd7);
        check("n_hold_idx",   32'(bus.o_chal_idx),  32'd3);

        // debug mode, mode dropped after start, tx_done noise ignored
        b_tx = tx_rises; b_dump = dump_rises; b_done = done_cyc; b_exec = exec_rises;
        tx_spam = 1'b1;
        start_batch(1'b1);
        send_word(8'h9A);
        send_word(8'hBC);
        send_word(8'hDE);
        send_word(8'hF0);
        wait_state(3'd0, 200, "d_end_idle");
        tx_spam = 1'b0;
        check("d_dump_bursts", 32'(dump_rises - b_dump), 32'd4);
        check("d_tx_bursts",   32'(tx_rises - b_tx),     32'd0);
        check("d_done_pulse",  32'(done_cyc - b_done),   32'd1);
        check("d_sel3",        32'(sel_log[(b_exec + 3) % 64]), 32'hF0);

        // timeout on challenge 1
        b_tx = tx_rises; b_done = done_cyc; b_exec = exec_rises; b_fall = exec_falls;
        skip_idx = 1;
        start_batch(1'b0);
        send_word(8'h21);
        send_word(8'h43);
        send_word(8'h65);
        send_word(8'h87);
        wait_state(3'd0, 300, "t_end_idle");
        skip_idx = -1;
        check("t_timeout",    32'(bus.o_timeout), 32'd1);
        check("t_exec_len",   32'(len_log[(b_fall + 1) % 64]), 32'd8);
        check("t_tx_bursts",  32'(tx_rises - b_tx), 32'd3);
        check("t_idx2_sel",   32'(sel_log[(b_exec + 2) % 64]), 32'h65);
        check("t_done_pulse", 32'(done_cyc - b_done), 32'd1);

        // exec_done on the last allowed cycle wins over timeout
        b_tx = tx_rises; b_fall = exec_falls;
        exec_lat = 8;
        start_batch(1'b0);
        check("l_timeout_clr", 32'(bus.o_timeout), 32'd0);
        send_word(8'h0F);
        send_word(8'h1E);
        send_word(8'h2D);
        send_word(8'h3C);
        wait_state(3'd0, 300, "l_end_idle");
        exec_lat = 3;
        check("l_timeout",   32'(bus.o_timeout), 32'd0);
        check("l_exec_len",  32'(len_log[b_fall % 64]), 32'd8);
        check("l_tx_bursts", 32'(tx_rises - b_tx), 32'd4);

        // valid in IDLE, gaps in RECEIVE, start during RECEIVE
        b_done = done_cyc; b_exec = exec_rises;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hEE;
        cyc(2);
        check("g_idle_valid", 32'(bus.o_fsm_state), 32'd0);
        bus.i_rx_valid = 1'b0;
        start_batch(1'b0);
        send_word(8'h11);
        bus.i_start = 1'b1;
        cyc(1);
        bus.i_start = 1'b0;
        check("g_start_ign", 32'(bus.o_fsm_state), 32'd1);
        send_word(8'h22);
        cyc(1);
        send_word(8'h33);
        cyc(1);
        check("g_three_words", 32'(bus.o_fsm_state), 32'd1);
        send_word(8'h44);
        check("g_decode_after4", 32'(bus.o_fsm_state), 32'd2);
        wait_state(3'd0, 200, "g_end_idle");
        check("g_sel0", 32'(sel_log[b_exec % 64]),       32'h11);
        check("g_sel3", 32'(sel_log[(b_exec + 3) % 64]), 32'h44);
        check("g_done_pulse", 32'(done_cyc - b_done), 32'd1);

        // abort during TRANSMIT of challenge 2, then a fresh batch
        b_tx = tx_rises; b_done = done_cyc;
        start_batch(1'b0);
        send_word(8'hA1);
        send_word(8'hB2);
        send_word(8'hC3);
        send_word(8'hD4);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.o_tx_enable && (bus.o_chal_idx == 2'd2)) begin
                hit = 1'b1;
                break;
            end
            cyc(1);
        end
        check("a_reach_tx2", 32'(hit), 32'd1);
        bus.i_abort = 1'b1;
        cyc(1);
        bus.i_abort = 1'b0;
        check("a_state", 32'(bus.o_fsm_state), 32'd0);
        check("a_outs",  32'(outs), 32'd0);
        check("a_idx",   32'(bus.o_chal_idx), 32'd0);
        cyc(3);
        check("a_no_done", 32'(done_cyc - b_done), 32'd0);
        b_exec = exec_rises;
        start_batch(1'b0);
        send_word(8'h5E);
        send_word(8'h6F);
        send_word(8'h70);
        send_word(8'h81);
        cyc(1);
        check("a_new_idx",  32'(bus.o_chal_idx), 32'd0);
        check("a_new_sel",  32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'h5E);
        wait_state(3'd0, 200, "a_end_idle");
        check("a_tx_total", 32'(tx_rises - b_tx), 32'd7);
        check("a_done_once", 32'(done_cyc - b_done), 32'd1);

        // asynchronous reset during EXECUTE
        b_done = done_cyc;
        start_batch(1'b0);
        send_word(8'h13);
        send_word(8'h24);
        send_word(8'h35);
        send_word(8'h46);
        cyc(1);
        check("r_in_exec", 32'(bus.o_fsm_state), 32'd3);
        rst = 1'b1;
        #2;
        check("r_async_state", 32'(bus.o_fsm_state), 32'd0);
        check("r_async_outs",  32'(outs), 32'd0);
        check("r_async_sel",   32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);
        start_batch(1'b0);
        send_word(8'h57);
        send_word(8'h68);
        send_word(8'h79);
        send_word(8'h8A);
        wait_state(3'd0, 200, "r_end_idle");
        check("r_done_pulse", 32'(done_cyc - b_done), 32'd1);
        check("r_last_sel",   32'({bus.o_sel_mux_1, bus.o_sel_mux_0}), 32'h8A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
